// File: rtl/mapping_pkg.sv
// Shared widths, default configuration and FSM encoding for the mapping
// request scheduler slice.
package mapping_pkg;

    localparam int unsigned REQ_W = 72;
    localparam int unsigned RSP_W = 48;
    localparam int unsigned CFG_W = 32;

    localparam logic [CFG_W-1:0] BASE_ADDR_DEFAULT = 32'h0010_0000;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/mapping_tag_fifo.sv
// In-order tag FIFO: remembers which client issued each outstanding lookup.
module mapping_tag_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok) count_d = count_q + 1'b1;
        if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mapping_req_sched.sv
// Two-client lookup scheduler in front of the mapping IP: sends the base
// address once, arbitrates requests round-robin and routes responses in order.
module mapping_req_sched
    import mapping_pkg::*;
#(
    parameter logic [CFG_W-1:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int unsigned      TAG_DEPTH = 8
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [REQ_W-1:0]           c0_req_tdata,
    input  logic                       c0_req_tvalid,
    output logic                       c0_req_tready,
    input  logic [REQ_W-1:0]           c1_req_tdata,
    input  logic                       c1_req_tvalid,
    output logic                       c1_req_tready,
    output logic [REQ_W-1:0]           m_req_tdata,
    output logic                       m_req_tvalid,
    input  logic                       m_req_tready,
    input  logic [RSP_W-1:0]           m_rsp_tdata,
    input  logic                       m_rsp_tvalid,
    output logic                       m_rsp_tready,
    output logic [RSP_W-1:0]           c0_rsp_tdata,
    output logic                       c0_rsp_tvalid,
    input  logic                       c0_rsp_tready,
    output logic [RSP_W-1:0]           c1_rsp_tdata,
    output logic                       c1_rsp_tvalid,
    input  logic                       c1_rsp_tready,
    output logic [CFG_W-1:0]           base_addr_tdata,
    output logic                       base_addr_tvalid,
    input  logic                       base_addr_tready,
    output logic [$clog2(TAG_DEPTH):0] outstanding,
    output logic                       rsp_err
);

    sched_state_t state_q, state_d;
    logic         rr_q, rr_d;
    logic         lock_q, lock_d;
    logic         lock_gnt_q, lock_gnt_d;
    logic         rsp_err_q, rsp_err_d;

    logic         run;
    logic         gnt;
    logic         gnt_valid;
    logic         push, pop;
    logic         tag_full, tag_empty, tag_head;

    assign run             = ap_rst_n && (state_q == ST_RUN);
    assign base_addr_tdata = BASE_ADDR;
    assign rsp_err         = rsp_err_q;

    always_comb begin
        state_d          = state_q;
        base_addr_tvalid = 1'b0;
        if (state_q == ST_INIT) begin
            base_addr_tvalid = 1'b1;
            if (base_addr_tready) state_d = ST_RUN;
        end
    end

    // A stalled beat locks the grant so tdata stays stable until accepted.
    always_comb begin
        if (lock_q)
            gnt = lock_gnt_q;
        else if (rr_q ? c1_req_tvalid : c0_req_tvalid)
            gnt = rr_q;
        else if (rr_q ? c0_req_tvalid : c1_req_tvalid)
            gnt = ~rr_q;
        else
            gnt = rr_q;
        gnt_valid = gnt ? c1_req_tvalid : c0_req_tvalid;
    end

    assign m_req_tdata   = gnt ? c1_req_tdata : c0_req_tdata;
    assign m_req_tvalid  = run && gnt_valid && !tag_full;
    assign c0_req_tready = run && !tag_full && m_req_tready && !gnt;
    assign c1_req_tready = run && !tag_full && m_req_tready && gnt;
    assign push          = m_req_tvalid && m_req_tready;

    always_comb begin
        rr_d       = rr_q;
        lock_d     = m_req_tvalid && !m_req_tready;
        lock_gnt_d = gnt;
        if (push) rr_d = ~gnt;
    end

    always_comb begin
        c0_rsp_tdata  = m_rsp_tdata;
        c1_rsp_tdata  = m_rsp_tdata;
        c0_rsp_tvalid = 1'b0;
        c1_rsp_tvalid = 1'b0;
        m_rsp_tready  = 1'b0;
        rsp_err_d     = rsp_err_q;
        if (ap_rst_n) begin
            if (!tag_empty) begin
                if (tag_head) begin
                    c1_rsp_tvalid = m_rsp_tvalid;
                    m_rsp_tready  = c1_rsp_tready;
                end else begin
                    c0_rsp_tvalid = m_rsp_tvalid;
                    m_rsp_tready  = c0_rsp_tready;
                end
            end else begin
                // Orphan response: drain it so the mapping IP cannot stall.
                m_rsp_tready = 1'b1;
                if (m_rsp_tvalid) rsp_err_d = 1'b1;
            end
        end
    end

    assign pop = m_rsp_tvalid && m_rsp_tready && !tag_empty;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= ST_INIT;
            rr_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_gnt_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_gnt_q <= lock_gnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    mapping_tag_fifo #(
        .WIDTH (1),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i   (ap_clk),
        .rst_ni  (ap_rst_n),
        .push_i  (push),
        .wdata_i (gnt),
        .pop_i   (pop),
        .rdata_o (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (outstanding)
    );

endmodule

// File: tb/tb_mapping_req_sched.sv
// Directed bench for mapping_req_sched with a response scoreboard queue.
module tb_mapping_req_sched;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [71:0] c0_req_tdata, c1_req_tdata, m_req_tdata;
    logic        c0_req_tvalid, c0_req_tready, c1_req_tvalid, c1_req_tready;
    logic        m_req_tvalid, m_req_tready;
    logic [47:0] m_rsp_tdata, c0_rsp_tdata, c1_rsp_tdata;
    logic        m_rsp_tvalid, m_rsp_tready;
    logic        c0_rsp_tvalid, c0_rsp_tready, c1_rsp_tvalid, c1_rsp_tready;
    logic [31:0] base_addr_tdata;
    logic        base_addr_tvalid, base_addr_tready;
    logic [3:0]  outstanding;
    logic        rsp_err;

    typedef struct {
        logic        cl;
        logic [47:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   hs_cnt = 0;

    always #5 ap_clk = ~ap_clk;

    mapping_req_sched #(
        .BASE_ADDR (32'h0010_0000),
        .TAG_DEPTH (8)
    ) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .c0_req_tdata     (c0_req_tdata),
        .c0_req_tvalid    (c0_req_tvalid),
        .c0_req_tready    (c0_req_tready),
        .c1_req_tdata     (c1_req_tdata),
        .c1_req_tvalid    (c1_req_tvalid),
        .c1_req_tready    (c1_req_tready),
        .m_req_tdata      (m_req_tdata),
        .m_req_tvalid     (m_req_tvalid),
        .m_req_tready     (m_req_tready),
        .m_rsp_tdata      (m_rsp_tdata),
        .m_rsp_tvalid     (m_rsp_tvalid),
        .m_rsp_tready     (m_rsp_tready),
        .c0_rsp_tdata     (c0_rsp_tdata),
        .c0_rsp_tvalid    (c0_rsp_tvalid),
        .c0_rsp_tready    (c0_rsp_tready),
        .c1_rsp_tdata     (c1_rsp_tdata),
        .c1_rsp_tvalid    (c1_rsp_tvalid),
        .c1_rsp_tready    (c1_rsp_tready),
        .base_addr_tdata  (base_addr_tdata),
        .base_addr_tvalid (base_addr_tvalid),
        .base_addr_tready (base_addr_tready),
        .outstanding      (outstanding),
        .rsp_err          (rsp_err)
    );

    // Inputs only change at posedge+1, so the negedge view is the handshake view.
    always @(negedge ap_clk) begin
        if (ap_rst_n && base_addr_tvalid && base_addr_tready) hs_cnt++;
    end

    task automatic nxt();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic half();
        @(negedge ap_clk);
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [47:0] rsp_of(input logic [71:0] r);
        return r[47:0] ^ 48'h5A5A_0000_FFFF;
    endfunction

    task automatic push_exp(input logic cl, input logic [71:0] r);
        exp_t e;
        e.cl = cl;
        e.d  = rsp_of(r);
        sb.push_back(e);
    endtask

    task automatic drain();
        int unsigned n;
        exp_t e;
        n = sb.size();
        c0_rsp_tready = 1'b1;
        c1_rsp_tready = 1'b1;
        for (int unsigned k = 0; k < n; k++) begin
            e = sb[0];
            m_rsp_tvalid = 1'b1;
            m_rsp_tdata  = e.d;
            half();
            chk("rsp_c0_valid", c0_rsp_tvalid, !e.cl);
            chk("rsp_c1_valid", c1_rsp_tvalid, e.cl);
            chk("rsp_data", e.cl ? c1_rsp_tdata : c0_rsp_tdata, e.d);
            chk("rsp_m_ready", m_rsp_tready, 1'b1);
            void'(sb.pop_front());
            nxt();
        end
        m_rsp_tvalid = 1'b0;
        half();
        chk("drained_outstanding", outstanding, 4'd0);
        nxt();
    endtask

    initial begin
        logic [71:0] d0, d1, da, db;
        logic        expc;

        ap_rst_n         = 1'b0;
        c0_req_tdata     = '0;
        c1_req_tdata     = '0;
        c0_req_tvalid    = 1'b0;
        c1_req_tvalid    = 1'b0;
        m_req_tready     = 1'b0;
        m_rsp_tdata      = '0;
        m_rsp_tvalid     = 1'b0;
        c0_rsp_tready    = 1'b0;
        c1_rsp_tready    = 1'b0;
        base_addr_tready = 1'b0;

        nxt();
        nxt();
        half();
        chk("rst_outstanding", outstanding, 4'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_m_req_tvalid", m_req_tvalid, 1'b0);
        chk("rst_m_rsp_tready", m_rsp_tready, 1'b0);
        chk("rst_base_tvalid", base_addr_tvalid, 1'b1);
        nxt();

        // Base address handshake held off for 5 cycles.
        ap_rst_n      = 1'b1;
        c0_req_tvalid = 1'b1;
        c0_req_tdata  = 72'hAA_0000_0000_0000_0001;
        for (int i = 0; i < 5; i++) begin
            half();
            chk("init_base_tvalid", base_addr_tvalid, 1'b1);
            chk("init_base_tdata", base_addr_tdata, 32'h0010_0000);
            chk("init_c0_tready", c0_req_tready, 1'b0);
            chk("init_m_req_tvalid", m_req_tvalid, 1'b0);
            nxt();
        end
        base_addr_tready = 1'b1;
        half();
        chk("init_base_tvalid_hs", base_addr_tvalid, 1'b1);
        nxt();
        c0_req_tvalid = 1'b0;
        m_req_tready  = 1'b1;
        half();
        chk("run_base_tvalid", base_addr_tvalid, 1'b0);
        chk("run_c0_tready", c0_req_tready, 1'b1);
        nxt();
        half();
        chk("base_handshakes", hs_cnt, 1);
        nxt();

        // Both clients valid: grants alternate starting at client 0.
        d0 = 72'h00_C000_0000_0000_0010;
        d1 = 72'h11_C100_0000_0000_0020;
        c0_req_tdata  = d0;
        c1_req_tdata  = d1;
        c0_req_tvalid = 1'b1;
        c1_req_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expc = (i % 2) == 1;
            half();
            chk("rr_c0_tready", c0_req_tready, !expc);
            chk("rr_c1_tready", c1_req_tready, expc);
            chk("rr_m_req_tdata", m_req_tdata, expc ? d1 : d0);
            push_exp(expc, expc ? d1 : d0);
            nxt();
            if (expc) d1 = d1 + 72'd1; else d0 = d0 + 72'd1;
            c0_req_tdata = d0;
            c1_req_tdata = d1;
        end
        c0_req_tvalid = 1'b0;
        c1_req_tvalid = 1'b0;
        half();
        chk("rr_outstanding", outstanding, 4'd4);
        nxt();
        drain();

        // Stalled c0 beat must hold while c1 becomes valid with priority.
        da = 72'h22_0000_AAAA_0000_0001;
        db = 72'h33_0000_BBBB_0000_0002;
        c0_req_tvalid = 1'b1;
        c0_req_tdata  = 72'h44_0000_CCCC_0000_0003;
        half();
        chk("pre_c0_tready", c0_req_tready, 1'b1);
        push_exp(1'b0, c0_req_tdata);
        nxt();
        c0_req_tdata = da;
        m_req_tready = 1'b0;
        half();
        chk("stall_m_req_tvalid", m_req_tvalid, 1'b1);
        chk("stall_tdata0", m_req_tdata, da);
        nxt();
        c1_req_tvalid = 1'b1;
        c1_req_tdata  = db;
        for (int i = 0; i < 3; i++) begin
            half();
            chk("stall_tdata_hold", m_req_tdata, da);
            chk("stall_c1_tready", c1_req_tready, 1'b0);
            nxt();
        end
        m_req_tready = 1'b1;
        half();
        chk("stall_accept_c0", c0_req_tready, 1'b1);
        chk("stall_accept_data", m_req_tdata, da);
        push_exp(1'b0, da);
        nxt();
        c0_req_tvalid = 1'b0;
        half();
        chk("after_stall_c1", c1_req_tready, 1'b1);
        chk("after_stall_data", m_req_tdata, db);
        push_exp(1'b1, db);
        nxt();
        c1_req_tvalid = 1'b0;
        half();
        chk("stall_outstanding", outstanding, 4'd3);
        nxt();
        drain();

        // Fill all 8 tags, then pop one while a new request waits.
        d0 = 72'h55_0000_0000_0000_0100;
        c0_req_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c0_req_tdata = d0;
            half();
            chk("fill_c0_tready", c0_req_tready, 1'b1);
            push_exp(1'b0, d0);
            nxt();
            d0 = d0 + 72'd1;
        end
        c0_req_tdata  = d0;
        c1_req_tvalid = 1'b1;
        c1_req_tdata  = 72'h66_0000_0000_0000_0200;
        half();
        chk("full_outstanding", outstanding, 4'd8);
        chk("full_c0_tready", c0_req_tready, 1'b0);
        chk("full_c1_tready", c1_req_tready, 1'b0);
        chk("full_m_req_tvalid", m_req_tvalid, 1'b0);
        nxt();
        m_rsp_tvalid  = 1'b1;
        m_rsp_tdata   = sb[0].d;
        c0_rsp_tready = 1'b1;
        half();
        chk("full_pop_rsp_valid", c0_rsp_tvalid, 1'b1);
        chk("full_pop_rsp_data", c0_rsp_tdata, sb[0].d);
        chk("full_pop_c0_tready", c0_req_tready, 1'b0);
        void'(sb.pop_front());
        nxt();
        m_rsp_tvalid  = 1'b0;
        c0_req_tvalid = 1'b0;
        c1_req_tvalid = 1'b0;
        half();
        chk("full_pop_outstanding", outstanding, 4'd7);
        nxt();
        drain();

        // Response with nothing outstanding.
        c0_rsp_tready = 1'b0;
        c1_rsp_tready = 1'b0;
        m_rsp_tvalid  = 1'b1;
        m_rsp_tdata   = 48'hDEAD_BEEF_0001;
        half();
        chk("orphan_m_rsp_tready", m_rsp_tready, 1'b1);
        chk("orphan_c0_valid", c0_rsp_tvalid, 1'b0);
        chk("orphan_c1_valid", c1_rsp_tvalid, 1'b0);
        chk("orphan_err_before", rsp_err, 1'b0);
        nxt();
        m_rsp_tvalid = 1'b0;
        half();
        chk("orphan_err_set", rsp_err, 1'b1);
        nxt();
        nxt();
        nxt();
        half();
        chk("orphan_err_sticky", rsp_err, 1'b1);
        nxt();

        // Reset with 3 lookups in flight.
        d0 = 72'h77_0000_0000_0000_0300;
        c0_req_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c0_req_tdata = d0;
            nxt();
            d0 = d0 + 72'd1;
        end
        c0_req_tvalid = 1'b0;
        half();
        chk("mid_outstanding", outstanding, 4'd3);
        nxt();
        ap_rst_n         = 1'b0;
        base_addr_tready = 1'b0;
        nxt();
        half();
        chk("rst2_outstanding", outstanding, 4'd0);
        chk("rst2_rsp_err", rsp_err, 1'b0);
        chk("rst2_base_tvalid", base_addr_tvalid, 1'b1);
        chk("rst2_m_rsp_tready", m_rsp_tready, 1'b0);
        chk("rst2_c0_tready", c0_req_tready, 1'b0);
        sb.delete();
        nxt();
        ap_rst_n = 1'b1;
        half();
        chk("rst2_init_base_tvalid", base_addr_tvalid, 1'b1);
        chk("rst2_init_c0_tready", c0_req_tready, 1'b0);
        nxt();
        base_addr_tready = 1'b1;
        nxt();
        half();
        chk("rst2_run_base_tvalid", base_addr_tvalid, 1'b0);
        chk("rst2_handshakes", hs_cnt, 2);
        chk("rst2_run_c0_tready", c0_req_tready, 1'b1);
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mapping_req_sched.md
MAPPING_REQ_SCHED -- requirements
Module: mapping_req_sched

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h100000: mapping-table DRAM base address written once after reset.
REQ-002 SHALL have parameter TAG_DEPTH, default 8: maximum outstanding lookups (power of 2, ≥2).
REQ-003 SHALL have port ap_clk, input, 1: single clock for all logic.
REQ-004 SHALL have port ap_rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports c0_req_tdata/tvalid/tready, in/in/out, 72/1/1: client 0 lookup requests.
REQ-006 SHALL have ports c1_req_tdata/tvalid/tready, in/in/out, 72/1/1: client 1 lookup requests.
REQ-007 SHALL have ports m_req_tdata/tvalid/tready, out/out/in, 72/1/1: requests to the mapping IP in_read stream.
REQ-008 SHALL have ports m_rsp_tdata/tvalid/tready, in/in/out, 48/1/1: responses from the mapping IP out_read stream.
REQ-009 SHALL have ports c0_rsp_tdata/tvalid/tready and c1_rsp_tdata/tvalid/tready, out/out/in, 48/1/1: per-client responses.
REQ-010 SHALL have ports base_addr_tdata/tvalid/tready, out/out/in, 32/1/1: base-address configuration to the mapping IP.
REQ-011 SHALL have port outstanding, output, $clog2(TAG_DEPTH)+1: lookups in flight.
REQ-012 SHALL have port rsp_err, output, 1: sticky flag for an unexpected response.

Function
REQ-013 SHALL implement FSM states INIT and RUN; INIT is entered from reset.
REQ-014 In INIT: base_addr_tvalid=1, base_addr_tdata=BASE_ADDR, m_req_tvalid=0, c0/c1_req_tready=0.
REQ-015 INIT→RUN on the cycle base_addr_tvalid&&base_addr_tready; base_addr_tvalid=0 from the next cycle; FSM never returns to INIT except via reset.
REQ-016 In RUN: arbitrate c0/c1 round-robin; rr pointer advances past the granted client only on an accepted beat (m_req_tvalid&&m_req_tready).
REQ-017 Once m_req_tvalid is asserted, grant and m_req_tdata SHALL be held until the handshake completes (AXIS stability), regardless of other client's tvalid.
REQ-018 m_req_tvalid = RUN && granted client tvalid && !tag_full; m_req_tdata = granted client tdata (combinational mux, zero added latency).
REQ-019 Granted client tready = m_req_tready && RUN && !tag_full; non-granted client tready = 0.
REQ-020 Each accepted request pushes its client id (1 bit) into an in-order tag FIFO of TAG_DEPTH entries.
REQ-021 Full boundary: when the FIFO is full, no request is accepted, even if a response pops in the same cycle (push is gated on the registered full flag).
REQ-022 Response routing: with FIFO not empty, m_rsp_tdata/tvalid pass combinationally to the client at the FIFO head; m_rsp_tready = that client's rsp_tready; other client rsp_tvalid = 0.
REQ-023 A FIFO pop SHALL occur on m_rsp_tvalid&&m_rsp_tready.
REQ-024 Simultaneous push and pop (not full) SHALL leave outstanding unchanged.
REQ-025 Empty boundary: a response arriving with an empty FIFO is consumed (m_rsp_tready=1), routed to no client, and sets rsp_err=1 until reset.
REQ-026 outstanding SHALL equal the FIFO occupancy, registered, 0..TAG_DEPTH; pointers wrap modulo TAG_DEPTH.

Reset
REQ-027 On ap_rst_n=0 at a clock edge: state=INIT, rr pointer=client 0, FIFO empty, outstanding=0, rsp_err=0, grant lock cleared.
REQ-028 Reset reasserted mid-operation SHALL discard all in-flight tags, and the base address SHALL be re-sent after deassertion.
REQ-029 During reset, all tvalid/tready outputs = 0, except base_addr_tvalid, which follows REQ-014 from the first cycle after reset.

Structure
REQ-030 Widths 72/48/32, BASE_ADDR default, and FSM state encoding SHALL reside in shared package mapping_pkg.
REQ-031 The tag FIFO SHALL be a sub-module, mapping_tag_fifo (width 1, depth TAG_DEPTH, full/empty/count).
REQ-032 Arbiter, FSM and response router SHALL reside in the top module; no DRAM interface logic.

Verification
REQ-033 Reset release, base_addr_tready held low 5 cycles, then high → base_addr_tvalid high throughout with tdata 32'h100000; c0_req_tready=0 until RUN; one handshake only.
REQ-034 Both clients continuously valid, m_req_tready=1 → grants alternate c0,c1,c0,c1; 4 responses routed in order c0,c1,c0,c1 with matching data.
REQ-035 c0 valid, m_req_tready=0 for 3 cycles while c1 asserts valid → m_req_tdata stays c0 data and stable; c1 is served next after accept.
REQ-036 8 requests issued, no responses → outstanding=8, all req_tready=0; one response popped with a new request in the same cycle → new request blocked, outstanding=7.
REQ-037 Response with outstanding=0 → m_rsp_tready=1, no client rsp_tvalid, rsp_err=1 and stays 1.
REQ-038 Reset asserted with outstanding=3 → outstanding=0, state INIT, base address re-sent after release.
